// File: rtl/ebpf_pkg.sv
// Shared eBPF fetch definitions: opcodes, slot field positions, FSM states,
// the decoded-instruction record and the slot-splitting helper.
package ebpf_pkg;

  localparam logic [7:0] OPC_LDDW = 8'h18;
  localparam logic [7:0] OPC_EXIT = 8'h95;

  localparam int OPC_LSB = 56;
  localparam int SRC_LSB = 52;
  localparam int DST_LSB = 48;
  localparam int OFF_LSB = 32;
  localparam int IMM_LSB = 0;

  // Widest PC the instruction record can carry; ADDR_W must not exceed it.
  localparam int PC_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_HI,
    ST_HOLD,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]          opcode;
    logic [3:0]          src;
    logic [3:0]          dst;
    logic [15:0]         offset;
    logic [63:0]         imm;
    logic [PC_MAX_W-1:0] pc;
    logic                wide;
  } instr_t;

  // Split one 64-bit slot into fields; imm is zero-extended low word.
  function automatic instr_t split_slot(input logic [63:0] slot,
                                        input logic [PC_MAX_W-1:0] pc);
    instr_t r;
    r.opcode = slot[OPC_LSB +: 8];
    r.src    = slot[SRC_LSB +: 4];
    r.dst    = slot[DST_LSB +: 4];
    r.offset = slot[OFF_LSB +: 16];
    r.imm    = {32'b0, slot[IMM_LSB +: 32]};
    r.pc     = pc;
    r.wide   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ebpf_fetch_unit.sv
// eBPF instruction-fetch unit: drives the instruction-memory address, splits
// slots into fields, merges two-slot lddw and hands instructions to decode
// over valid/ready. Optional retired-instruction counter: EBPF_FETCH_PERF_EN.
module ebpf_fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [3:0]        instr_src,
  output logic [3:0]        instr_dst,
  output logic [15:0]       instr_offset,
  output logic [63:0]       instr_imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_wide,
  output logic              busy,
  output logic              fault,
  output logic [31:0]       instr_count
);
  import ebpf_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  instr_t            instr_q;
  logic              valid_q;
  logic              fault_q;

  logic              idle_like;
  logic              hs;

  instr_t            cap;
  fetch_state_t      fst_nx;
  logic              fvld_nx;
  logic              ffault_nx;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_FAULT);
  assign hs        = valid_q & instr_ready;

  // Outcome of capturing the slot at pc: single-slot goes straight to HOLD,
  // lddw needs its high slot unless it sits on the last address.
  always_comb begin
    cap       = split_slot(mem_data[63:0], PC_MAX_W'(pc_q));
    fst_nx    = ST_HOLD;
    fvld_nx   = 1'b1;
    ffault_nx = 1'b0;
    if (cap.opcode == OPC_LDDW) begin
      fvld_nx = 1'b0;
      if (&pc_q) begin
        fst_nx    = ST_FAULT;
        ffault_nx = 1'b1;
      end else begin
        fst_nx = ST_FETCH_HI;
      end
    end
  end

  // Fetch FSM; redirect beats any handshake in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT, ST_FAULT: begin
          if (start) begin
            state_q <= ST_FETCH;
            pc_q    <= start_pc;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          if (redirect) begin
            state_q <= ST_FETCH;
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
          end else if (state_q == ST_FETCH_HI) begin
            instr_q.imm[63:32] <= mem_data[31:0];
            instr_q.wide       <= 1'b1;
            state_q            <= ST_HOLD;
            valid_q            <= 1'b1;
            pc_q               <= pc_q + PC_ONE;
          end else if (state_q == ST_FETCH || hs) begin
            if (state_q == ST_HOLD && instr_q.opcode == OPC_EXIT) begin
              state_q <= ST_HALT;
              valid_q <= 1'b0;
            end else begin
              instr_q <= cap;
              state_q <= fst_nx;
              valid_q <= fvld_nx;
              fault_q <= ffault_nx;
              if (fst_nx != ST_FAULT) pc_q <= pc_q + PC_ONE;
            end
          end
        end
      endcase
    end
  end

`ifdef EBPF_FETCH_PERF_EN
  logic [31:0] cnt_q;
  logic        count_hs;

  assign count_hs = (state_q == ST_HOLD) && hs && !redirect;

  // Retired-instruction counter; an accepted start restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               cnt_q <= '0;
    else if (idle_like & start) cnt_q <= '0;
    else if (count_hs)          cnt_q <= cnt_q + 32'd1;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 32'd0;
`endif

  // Record pc is wider than ADDR_W; the spare upper bits are always zero.
  logic unused_pc;
  assign unused_pc = ^instr_q.pc[PC_MAX_W-1:ADDR_W];

  assign mem_address  = pc_q;
  assign instr_valid  = valid_q;
  assign instr_opcode = instr_q.opcode;
  assign instr_src    = instr_q.src;
  assign instr_dst    = instr_q.dst;
  assign instr_offset = instr_q.offset;
  assign instr_imm    = instr_q.imm;
  assign instr_pc     = instr_q.pc[ADDR_W-1:0];
  assign instr_wide   = instr_q.wide;
  assign busy         = !idle_like;
  assign fault        = fault_q;

endmodule

// File: tb/tb_ebpf_fetch_unit.sv
// Directed bench for ebpf_fetch_unit: table of expected instructions plus
// hand sequences for stall, redirect, fault, pc wrap and mid-fetch reset.
module tb_ebpf_fetch_unit;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr_opcode;
  logic [3:0]    instr_src;
  logic [3:0]    instr_dst;
  logic [15:0]   instr_offset;
  logic [63:0]   instr_imm;
  logic [AW-1:0] instr_pc;
  logic          instr_wide;
  logic          busy;
  logic          fault;
  logic [31:0]   instr_count;

  logic [63:0] mem [0:(1<<AW)-1];
  assign mem_data = mem[mem_address];

  always #5 clk = ~clk;

  ebpf_fetch_unit #(.ADDR_W(AW), .DATA_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .mem_address(mem_address),
    .mem_data(mem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_src(instr_src), .instr_dst(instr_dst),
    .instr_offset(instr_offset), .instr_imm(instr_imm), .instr_pc(instr_pc),
    .instr_wide(instr_wide), .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [7:0]    op;
    logic [3:0]    src;
    logic [3:0]    dst;
    logic [15:0]   off;
    logic [63:0]   imm;
    logic          wide;
    logic [AW-1:0] nxt;   // mem_address while this instruction is presented
  } exp_t;

  exp_t tbl [14];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef EBPF_FETCH_PERF_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // Wait (bounded) for valid, then compare against table entry idx.
  task automatic check_entry(input int idx);
    int n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("e%0d_valid", idx), {63'b0, instr_valid}, 64'd1);
    chk($sformatf("e%0d_pc", idx),    {52'b0, instr_pc},     {52'b0, tbl[idx].pc});
    chk($sformatf("e%0d_op", idx),    {56'b0, instr_opcode}, {56'b0, tbl[idx].op});
    chk($sformatf("e%0d_src", idx),   {60'b0, instr_src},    {60'b0, tbl[idx].src});
    chk($sformatf("e%0d_dst", idx),   {60'b0, instr_dst},    {60'b0, tbl[idx].dst});
    chk($sformatf("e%0d_off", idx),   {48'b0, instr_offset}, {48'b0, tbl[idx].off});
    chk($sformatf("e%0d_imm", idx),   instr_imm,             tbl[idx].imm);
    chk($sformatf("e%0d_wide", idx),  {63'b0, instr_wide},   {63'b0, tbl[idx].wide});
    chk($sformatf("e%0d_addr", idx),  {52'b0, mem_address},  {52'b0, tbl[idx].nxt});
  endtask

  task automatic run_entries(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      check_entry(i);
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] pc);
    start    = 1'b1;
    start_pc = pc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {63'b0, instr_valid}, 64'd0);
    chk({tag, "_busy"},  {63'b0, busy},        64'd0);
    chk({tag, "_fault"}, {63'b0, fault},       64'd0);
    chk({tag, "_addr"},  {52'b0, mem_address}, 64'd0);
    chk({tag, "_op"},    {56'b0, instr_opcode},64'd0);
    chk({tag, "_imm"},   instr_imm,            64'd0);
    chk({tag, "_pc"},    {52'b0, instr_pc},    64'd0);
    chk({tag, "_wide"},  {63'b0, instr_wide},  64'd0);
    chk({tag, "_cnt"},   {32'b0, instr_count}, 64'd0);
  endtask

  initial begin
    tbl[0]  = '{12'd0,    8'h07, 4'h0, 4'h0, 16'h0000, 64'h5,                 1'b0, 12'd1};
    tbl[1]  = '{12'd1,    8'hB7, 4'h2, 4'h1, 16'h0000, 64'h1,                 1'b0, 12'd2};
    tbl[2]  = '{12'd2,    8'h95, 4'h0, 4'h0, 16'h0000, 64'h0,                 1'b0, 12'd3};
    tbl[3]  = '{12'd4,    8'h18, 4'h0, 4'h1, 16'h0000, 64'hCAFEF00D_DEADBEEF, 1'b1, 12'd6};
    tbl[4]  = '{12'd6,    8'h95, 4'h0, 4'h0, 16'h0000, 64'h0,                 1'b0, 12'd7};
    tbl[5]  = '{12'd32,   8'h07, 4'h0, 4'h0, 16'h0004, 64'h00000000_FFFFFFFF, 1'b0, 12'd33};
    tbl[6]  = '{12'd10,   8'hB7, 4'h0, 4'h3, 16'h0000, 64'hA,                 1'b0, 12'd11};
    tbl[7]  = '{12'd11,   8'h95, 4'h0, 4'h0, 16'h0000, 64'h0,                 1'b0, 12'd12};
    tbl[8]  = '{12'd4095, 8'h07, 4'h0, 4'h0, 16'h0000, 64'h7,                 1'b0, 12'd0};
    tbl[9]  = tbl[0];
    tbl[10] = tbl[1];
    tbl[11] = tbl[2];
    tbl[12] = '{12'd20,   8'h61, 4'h4, 4'h5, 16'hFFFE, 64'h00000000_80000000, 1'b0, 12'd21};
    tbl[13] = '{12'd21,   8'h95, 4'h0, 4'h0, 16'h0000, 64'h0,                 1'b0, 12'd22};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 64'h0;
    mem[0]    = 64'h07_00_0000_00000005;
    mem[1]    = 64'hB7_21_0000_00000001;
    mem[2]    = 64'h95_00_0000_00000000;
    mem[4]    = 64'h18_01_0000_DEADBEEF;
    mem[5]    = 64'h00000000_CAFEF00D;
    mem[6]    = 64'h95_00_0000_00000000;
    mem[10]   = 64'hB7_03_0000_0000000A;
    mem[11]   = 64'h95_00_0000_00000000;
    mem[20]   = 64'h61_45_FFFE_80000000;
    mem[21]   = 64'h95_00_0000_00000000;
    mem[32]   = 64'h07_00_0004_FFFFFFFF;
    mem[33]   = 64'h07_00_0000_00000009;
    mem[4095] = 64'h18_00_0000_12345678;

    reset_n = 1'b0; start = 1'b0; start_pc = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Straight-line program ending in exit.
    pulse_start(12'd0);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    run_entries(0, 3);
    chk("t1_halt_busy",  {63'b0, busy},        64'd0);
    chk("t1_halt_valid", {63'b0, instr_valid}, 64'd0);
    chk("t1_cnt",        {32'b0, instr_count}, {32'b0, cnt_exp(32'd3)});

    // lddw merge, then exit at pc 6.
    pulse_start(12'd4);
    run_entries(3, 2);
    chk("t2_cnt", {32'b0, instr_count}, {32'b0, cnt_exp(32'd2)});

    // Stall with ready low; a start while busy must be ignored.
    instr_ready = 1'b0;
    pulse_start(12'd20);
    check_entry(12);
    for (int c = 0; c < 5; c++) begin
      start    = (c == 2);
      start_pc = 12'd0;
      @(negedge clk);
      chk($sformatf("t3_pc%0d", c),   {52'b0, instr_pc},     64'd20);
      chk($sformatf("t3_op%0d", c),   {56'b0, instr_opcode}, 64'h61);
      chk($sformatf("t3_imm%0d", c),  instr_imm,             64'h80000000);
      chk($sformatf("t3_addr%0d", c), {52'b0, mem_address},  64'd21);
      chk($sformatf("t3_vld%0d", c),  {63'b0, instr_valid},  64'd1);
      chk($sformatf("t3_cnt%0d", c),  {32'b0, instr_count},  64'd0);
    end
    start = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    run_entries(13, 1);

    // Redirect coinciding with handshake of pc 33: dropped, not counted.
    pulse_start(12'd32);
    run_entries(5, 1);
    chk("t4_pc33", {52'b0, instr_pc}, 64'd33);
    redirect    = 1'b1;
    redirect_pc = 12'd10;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_valid", {63'b0, instr_valid}, 64'd0);
    chk("t4_cnt",   {32'b0, instr_count}, {32'b0, cnt_exp(32'd1)});
    run_entries(6, 2);
    chk("t4_cnt_end", {32'b0, instr_count}, {32'b0, cnt_exp(32'd3)});

    // lddw on the last slot faults; start clears it.
    pulse_start(12'd4095);
    begin
      int n = 0;
      while (!fault && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_fault", {63'b0, fault},       64'd1);
    chk("t5_valid", {63'b0, instr_valid}, 64'd0);
    chk("t5_busy",  {63'b0, busy},        64'd0);
    @(negedge clk);
    chk("t5_sticky", {63'b0, fault}, 64'd1);
    mem[4095] = 64'h07_00_0000_00000007;
    pulse_start(12'd4095);
    chk("t5_clr", {63'b0, fault}, 64'd0);
    // Single-slot wrap from the last address back to 0.
    run_entries(8, 4);
    chk("t5_cnt", {32'b0, instr_count}, {32'b0, cnt_exp(32'd4)});

    // Reset asserted while waiting for lddw high slot.
    pulse_start(12'd4);
    @(negedge clk);
    chk("t6_busy",  {63'b0, busy},        64'd1);
    chk("t6_valid", {63'b0, instr_valid}, 64'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("t6");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
